// File: rtl/i4001_bank.sv
// Bank of NUM_CHIPS emulated 4001 ROM/I-O chips sharing one ROM read port and one CPU data bus.
// Optional: define I4001_BANK_IOCHG_EN to add per-chip input-change flags on port io_chg.

module i4001_bank_io #(
    parameter logic [3:0] OUT_MASK = 4'h0,
    parameter logic [3:0] INV_MASK = 4'h0,
    parameter logic [3:0] RST_VAL  = 4'h0
) (
    input  logic       sysclk,
    input  logic       poc_n,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [3:0] wr_data,
    input  logic [3:0] pin_in,
    output logic [3:0] pin_out,
    output logic [3:0] rd_data
`ifdef I4001_BANK_IOCHG_EN
    ,
    input  logic       chg_clr,
    output logic       chg
`endif
);
    logic [3:0] lat_q, lat_d, sync1_q, sync2_q;

    always_comb begin
        lat_d = lat_q;
        if (wr_en) lat_d = wr_data & OUT_MASK;
        if (clear) lat_d = RST_VAL & OUT_MASK;
    end

    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            lat_q   <= RST_VAL & OUT_MASK;
            sync1_q <= 4'h0;
            sync2_q <= 4'h0;
        end else begin
            lat_q   <= lat_d;
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
        end
    end

    assign pin_out = (lat_q ^ INV_MASK) & OUT_MASK;
    // Output pins read back their own latch; input pins read the synchronised pin.
    assign rd_data = (lat_q & OUT_MASK) | ((sync2_q ^ INV_MASK) & ~OUT_MASK);

`ifdef I4001_BANK_IOCHG_EN
    logic [3:0] prev_q;
    logic       chg_q, chg_d;

    always_comb begin
        chg_d = chg_q;
        if (chg_clr) chg_d = 1'b0;
        if (|((sync2_q ^ prev_q) & ~OUT_MASK)) chg_d = 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            prev_q <= 4'h0;
            chg_q  <= 1'b0;
        end else begin
            prev_q <= sync2_q;
            chg_q  <= chg_d;
        end
    end

    assign chg = chg_q;
`endif
endmodule

module i4001_bank #(
    parameter int                     NUM_CHIPS = 4,
    parameter int                     BASE_CHIP = 0,
    parameter logic [4*NUM_CHIPS-1:0] IO_OUTPUT = '0,
    parameter logic [4*NUM_CHIPS-1:0] IO_INVERT = '0,
    parameter logic [4*NUM_CHIPS-1:0] IO_RESET  = '0
) (
    input  logic                   sysclk,
    input  logic                   poc_n,
    input  logic                   clk2,
    input  logic                   cmrom,
    input  logic                   a12,
    input  logic                   a22,
    input  logic                   a32,
    input  logic                   m11,
    input  logic                   m12,
    input  logic                   m21,
    input  logic                   m22,
    input  logic                   x21,
    input  logic                   x22,
    input  logic [3:0]             data_in,
    output logic [3:0]             data_out,
    output logic                   data_dir,
    output logic [11:0]            rom_addr,
    input  logic [7:0]             rom_data,
    input  logic [4*NUM_CHIPS-1:0] io_in,
    output logic [4*NUM_CHIPS-1:0] io_out,
    input  logic                   clear
`ifdef I4001_BANK_IOCHG_EN
    ,
    output logic [NUM_CHIPS-1:0]   io_chg
`endif
);
    logic [7:0]  addr_q, addr_d;
    logic        sel_q, sel_d;
    logic [11:0] rom_addr_q, rom_addr_d;
    logic        src_valid_q, src_valid_d;
    logic [3:0]  src_idx_q, src_idx_d;
    logic        rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
    logic [3:0]  dout_q, dout_d, rd_mux;
    logic        ddir_q, ddir_d;
    logic [5:0]  rel;
    logic        in_rng;

    logic [NUM_CHIPS-1:0][3:0] rd_nib;

    // Offset from BASE_CHIP; values below the base wrap far above NUM_CHIPS.
    always_comb begin
        rel         = {2'b00, data_in} - 6'(BASE_CHIP);
        in_rng      = (rel < 6'(NUM_CHIPS));
        addr_d      = addr_q;
        sel_d       = sel_q;
        rom_addr_d  = rom_addr_q;
        src_valid_d = src_valid_q;
        src_idx_d   = src_idx_q;
        rd_pend_d   = rd_pend_q;
        wr_pend_d   = wr_pend_q;
        if (clk2 && a22) addr_d[7:4] = data_in;
        if (clk2 && a32) begin
            sel_d      = cmrom & in_rng;
            rom_addr_d = (cmrom && in_rng) ? {data_in, addr_q} : 12'h000;
        end
        if (clk2 && x22 && cmrom) begin
            src_valid_d = in_rng;
            src_idx_d   = rel[3:0];
        end
        if (clk2 && m22 && cmrom && src_valid_q) begin
            if (data_in == 4'b1010) rd_pend_d = 1'b1;
            if (data_in == 4'b0010) wr_pend_d = 1'b1;
        end
        if (clk2 && a12) begin
            addr_d[3:0] = data_in;
            sel_d       = 1'b0;
            rom_addr_d  = 12'h000;
            rd_pend_d   = 1'b0;
            wr_pend_d   = 1'b0;
        end
    end

    always_comb begin
        rd_mux = 4'h0;
        for (int k = 0; k < NUM_CHIPS; k++)
            if (src_idx_q == 4'(k)) rd_mux = rd_nib[k];
    end

    always_comb begin
        ddir_d = 1'b0;
        dout_d = 4'h0;
        if (sel_q && (m11 || m12)) begin
            ddir_d = 1'b1;
            dout_d = rom_data[7:4];
        end else if (sel_q && (m21 || m22)) begin
            ddir_d = 1'b1;
            dout_d = rom_data[3:0];
        end else if (rd_pend_q && (x21 || x22)) begin
            ddir_d = 1'b1;
            dout_d = rd_mux;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            addr_q      <= 8'h00;
            sel_q       <= 1'b0;
            rom_addr_q  <= 12'h000;
            src_valid_q <= 1'b0;
            src_idx_q   <= 4'h0;
            rd_pend_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            dout_q      <= 4'h0;
            ddir_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            rom_addr_q  <= rom_addr_d;
            src_valid_q <= src_valid_d;
            src_idx_q   <= src_idx_d;
            rd_pend_q   <= rd_pend_d;
            wr_pend_q   <= wr_pend_d;
            dout_q      <= dout_d;
            ddir_q      <= ddir_d;
        end
    end

    for (genvar k = 0; k < NUM_CHIPS; k++) begin : g_chip
        logic wr_en;
        assign wr_en = wr_pend_q & x22 & clk2 & (src_idx_q == 4'(k));

        i4001_bank_io #(
            .OUT_MASK (IO_OUTPUT[4*k +: 4]),
            .INV_MASK (IO_INVERT[4*k +: 4]),
            .RST_VAL  (IO_RESET[4*k +: 4])
        ) u_io (
            .sysclk  (sysclk),
            .poc_n   (poc_n),
            .clear   (clear),
            .wr_en   (wr_en),
            .wr_data (data_in),
            .pin_in  (io_in[4*k +: 4]),
            .pin_out (io_out[4*k +: 4]),
            .rd_data (rd_nib[k])
`ifdef I4001_BANK_IOCHG_EN
            ,
            .chg_clr (rd_pend_q & x22 & clk2 & (src_idx_q == 4'(k))),
            .chg     (io_chg[k])
`endif
        );
    end

    assign data_out = dout_q;
    assign data_dir = ddir_q;
    assign rom_addr = rom_addr_q;
endmodule

// File: tb/tb_i4001_bank.sv
// Scoreboard bench for i4001_bank: NUM_CHIPS=4, BASE_CHIP=2, bus cycles of 8 phases x 4 sysclk.
module tb_i4001_bank;
    localparam logic [15:0] OUTM = 16'hFF00;
    localparam logic [15:0] INVM = 16'h5102;
    localparam logic [15:0] RSTV = 16'hA300;

    logic        sysclk = 1'b0;
    logic        poc_n, clk2, cmrom, a12, a22, a32, m11, m12, m21, m22, x21, x22, clear;
    logic [3:0]  data_in, data_out;
    logic        data_dir;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] io_in, io_out;
`ifdef I4001_BANK_IOCHG_EN
    logic [3:0]  io_chg;
`endif

    typedef struct {
        string       tag;
        int          sig;
        logic [15:0] exp;
    } sb_t;
    sb_t sb_q[$];

    int n_chk = 0, n_err = 0;

    logic        srcv_m;
    logic [3:0]  sidx_m;
    logic [15:0] lat_m;

    i4001_bank #(
        .NUM_CHIPS (4),
        .BASE_CHIP (2),
        .IO_OUTPUT (OUTM),
        .IO_INVERT (INVM),
        .IO_RESET  (RSTV)
    ) dut (
        .sysclk   (sysclk),
        .poc_n    (poc_n),
        .clk2     (clk2),
        .cmrom    (cmrom),
        .a12      (a12),
        .a22      (a22),
        .a32      (a32),
        .m11      (m11),
        .m12      (m12),
        .m21      (m21),
        .m22      (m22),
        .x21      (x21),
        .x22      (x22),
        .data_in  (data_in),
        .data_out (data_out),
        .data_dir (data_dir),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .io_in    (io_in),
        .io_out   (io_out),
        .clear    (clear)
`ifdef I4001_BANK_IOCHG_EN
        ,
        .io_chg   (io_chg)
`endif
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [7:0] rom_fn(input logic [11:0] a);
        if (a == 12'h35A) return 8'hC7;
        return a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] obs(input int sig);
        case (sig)
            0:       return {15'h0, data_dir};
            1:       return {12'h0, data_out};
            2:       return {4'h0, rom_addr};
            3:       return io_out;
`ifdef I4001_BANK_IOCHG_EN
            4:       return {15'h0, io_chg[0]};
`endif
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic sb_push(input string tag, input int sig, input logic [15:0] exp);
        sb_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, obs(e.sig), e.exp);
        end
    endtask

    function automatic logic in_rng(input logic [3:0] c);
        return (c >= 4'd2) && (c <= 4'd5);
    endfunction

    function automatic logic [3:0] rdback(input logic [3:0] k);
        logic [3:0] om;
        om = OUTM[int'(k)*4 +: 4];
        return (lat_m[int'(k)*4 +: 4] & om) | ((io_in[int'(k)*4 +: 4] ^ INVM[int'(k)*4 +: 4]) & ~om);
    endfunction

    task automatic reset_model();
        srcv_m = 1'b0;
        sidx_m = 4'h0;
        lat_m  = RSTV & OUTM;
    endtask

    task automatic drive_idle();
        {clk2, cmrom, a12, a22, a32, m11, m12, m21, m22, x21, x22, clear} = '0;
        data_in = 4'h0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) @(negedge sysclk);
    endtask

    // One instruction cycle; fetch from `chip`/`addr`, OPA on the bus in M2, `x2d` in X2.
    task automatic run_cycle(input logic [3:0] chip, input logic [7:0] addr, input logic cm_m2,
                             input logic [3:0] opa, input logic cm_x2, input logic [3:0] x2d,
                             input logic clr_x2, input int rst_at);
        logic sel_m, rdp, wrp, hi, edir;
        logic [11:0] ra;
        logic [7:0] rw;
        logic [3:0] edo;
        int st;
        sel_m = 1'b0; rdp = 1'b0; wrp = 1'b0; ra = 12'h0;
        for (int ph = 0; ph < 8; ph++) begin
            for (int c = 0; c < 4; c++) begin
                st = ph * 4 + c;
                hi = (c >= 2);
                data_in = (ph == 0) ? addr[3:0] : (ph == 1) ? addr[7:4] : (ph == 2) ? chip :
                          (ph == 4) ? opa : (ph == 6) ? x2d : 4'h0;
                clk2  = hi;
                a12   = (ph == 0) && hi;
                a22   = (ph == 1) && hi;
                a32   = (ph == 2) && hi;
                m11   = (ph == 3) && !hi;
                m12   = (ph == 3) && hi;
                m21   = (ph == 4) && !hi;
                m22   = (ph == 4) && hi;
                x21   = (ph == 6) && !hi;
                x22   = (ph == 6) && hi;
                cmrom = (ph == 2) || (ph == 4 && cm_m2) || (ph == 6 && cm_x2);
                clear = clr_x2 && (ph == 6) && hi;
                poc_n = (st != rst_at);
                rw    = rom_fn(ra);
                edir  = 1'b0;
                edo   = 4'h0;
                if (st != rst_at) begin
                    if (sel_m && ph == 3) begin edir = 1'b1; edo = rw[7:4]; end
                    if (sel_m && ph == 4) begin edir = 1'b1; edo = rw[3:0]; end
                    if (rdp && ph == 6)   begin edir = 1'b1; edo = rdback(sidx_m); end
                end
                if (st == rst_at) begin
                    sel_m = 1'b0; ra = 12'h0; rdp = 1'b0; wrp = 1'b0;
                    reset_model();
                end else if (hi) begin
                    if (ph == 0) begin sel_m = 1'b0; ra = 12'h0; rdp = 1'b0; wrp = 1'b0; end
                    if (ph == 2) begin sel_m = in_rng(chip); ra = sel_m ? {chip, addr} : 12'h0; end
                    if (ph == 4 && cm_m2 && srcv_m) begin
                        rdp = rdp | (opa == 4'hA);
                        wrp = wrp | (opa == 4'h2);
                    end
                    if (ph == 6) begin
                        if (clr_x2) lat_m = RSTV & OUTM;
                        else if (wrp) lat_m[int'(sidx_m)*4 +: 4] = x2d & OUTM[int'(sidx_m)*4 +: 4];
                        if (cm_x2) begin srcv_m = in_rng(x2d); sidx_m = x2d - 4'd2; end
                    end
                end
                sb_push($sformatf("dir c%0h ph%0d.%0d", chip, ph, c), 0, {15'h0, edir});
                if (edir) sb_push($sformatf("dout c%0h ph%0d.%0d", chip, ph, c), 1, {12'h0, edo});
                if (ph == 3) sb_push($sformatf("rom_addr c%0h ph3.%0d", chip, c), 2, {4'h0, ra});
                @(negedge sysclk);
                drain();
            end
        end
        poc_n = 1'b1;
        drive_idle();
        sb_push("io_out", 3, (lat_m ^ INVM) & OUTM);
        drain();
    endtask

    task automatic fetch(input logic [3:0] chip, input logic [7:0] addr);
        run_cycle(chip, addr, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, -1);
    endtask

    task automatic src(input logic [3:0] chip);
        run_cycle(4'h6, 8'h00, 1'b0, 4'h0, 1'b1, chip, 1'b0, -1);
    endtask

    task automatic rdr();
        run_cycle(4'h6, 8'h01, 1'b1, 4'hA, 1'b0, 4'h0, 1'b0, -1);
    endtask

    task automatic wrr(input logic [3:0] d, input logic clr);
        run_cycle(4'h6, 8'h02, 1'b1, 4'h2, 1'b0, d, clr, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        io_in = 16'h0000;
        drive_idle();
        poc_n = 1'b0;
        repeat (3) @(negedge sysclk);
        reset_model();
        sb_push("rst dir", 0, 16'h0);
        sb_push("rst dout", 1, 16'h0);
        sb_push("rst rom_addr", 2, 16'h0);
        sb_push("rst io_out", 3, (RSTV ^ INVM) & OUTM);
`ifdef I4001_BANK_IOCHG_EN
        sb_push("rst io_chg0", 4, 16'h0);
`endif
        drain();
        poc_n = 1'b1;
        io_in = 16'h0065;
        idle(4);

        fetch(4'h3, 8'h5A);
        fetch(4'h6, 8'h12);
        fetch(4'h1, 8'h34);
        fetch(4'h5, 8'hFF);
        fetch(4'h2, 8'h00);

        src(4'h4); wrr(4'h9, 1'b0);
        src(4'h3); rdr();
        src(4'h2); rdr();
        src(4'h5); rdr(); wrr(4'h3, 1'b0);
        src(4'h7); wrr(4'hF, 1'b0); rdr();
        src(4'h4); run_cycle(4'h6, 8'h03, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, -1);
        src(4'h4); wrr(4'h5, 1'b1);

        run_cycle(4'h3, 8'h5A, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 13);
        fetch(4'h3, 8'hA5);

`ifdef I4001_BANK_IOCHG_EN
        sb_push("chg after reset", 4, 16'h1);
        drain();
        src(4'h2); rdr();
        sb_push("chg cleared", 4, 16'h0);
        drain();
        io_in = io_in ^ 16'h0001;
        idle(3);
        sb_push("chg on toggle", 4, 16'h1);
        drain();
        rdr();
        sb_push("chg cleared again", 4, 16'h0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
